// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: opcodes, ALU op encoding, immediate formats and
// the decoded bundle passed from decode to execute.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_t;

  typedef struct packed {
    alu_op_t     alu_ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic [2:0]  funct3;
    logic        illegal;
  } decoded_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_fmt_t f);
    logic [31:0] v;
    case (f)
      IMM_I:   v = {{20{i[31]}}, i[31:20]};
      IMM_S:   v = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   v = {i[31:12], 12'b0};
      IMM_J:   v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decoder: raw instruction word to decoded_t bundle.
module rv32i_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  imm_fmt_t   fmt;
  logic       legal;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  always_comb begin
    dec        = '0;
    fmt        = IMM_NONE;
    legal      = 1'b1;
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.rd     = instr[11:7];
    dec.funct3 = f3;
    case (opc)
      OPC_OP: begin
        legal         = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        dec.alu_ctrl  = alu_op_t'({instr[30], f3});
        dec.reg_write = 1'b1;
      end
      OPC_OPIMM: begin
        fmt           = IMM_I;
        dec.alu_src_b = 1'b1;
        dec.reg_write = 1'b1;
        // bit30 only qualifies shifts; for addi etc. it is just immediate data
        if (f3 == 3'b001) begin
          legal        = (f7 == 7'b0000000);
          dec.alu_ctrl = ALU_SLL;
        end else if (f3 == 3'b101) begin
          legal        = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          dec.alu_ctrl = alu_op_t'({instr[30], f3});
        end else begin
          dec.alu_ctrl = alu_op_t'({1'b0, f3});
        end
      end
      OPC_LOAD: begin
        fmt           = IMM_I;
        legal         = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        dec.alu_src_b = 1'b1;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        fmt           = IMM_S;
        legal         = (f3 < 3'b011);
        dec.alu_src_b = 1'b1;
        dec.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        fmt        = IMM_B;
        dec.branch = 1'b1;
        case (f3[2:1])
          2'b00:   dec.alu_ctrl = ALU_SUB;
          2'b10:   dec.alu_ctrl = ALU_SLT;
          2'b11:   dec.alu_ctrl = ALU_SLTU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        fmt           = IMM_U;
        dec.rs1       = 5'd0;
        dec.alu_src_b = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        fmt           = IMM_U;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        // ALU forms the target as PC + imm
        fmt           = IMM_J;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
      end
      OPC_JALR: begin
        fmt           = IMM_I;
        legal         = (f3 == 3'b000);
        dec.alu_src_b = 1'b1;
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    dec.imm = gen_imm(instr, fmt);
    // illegal ops reach execute inert, carrying only the trap marker
    if (!legal) begin
      dec.alu_ctrl  = ALU_ADD;
      dec.imm       = '0;
      dec.alu_src_a = 1'b0;
      dec.alu_src_b = 1'b0;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: valid/ready skid-free pipeline register around the
// combinational decoder, with stall and flush.
module decode_stage
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [3:0]  alu_ctrl,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic [2:0]  funct3,
  output logic        illegal
);

  decoded_t    dec_d, dec_q;
  logic [31:0] pc_q;
  logic        vld_q;

  rv32i_decoder u_dec (
    .instr (in_instr),
    .dec   (dec_d)
  );

  assign in_ready = !vld_q || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      dec_q <= '0;
      pc_q  <= '0;
    end else begin
      if (flush)         vld_q <= 1'b0;
      else if (in_ready) vld_q <= in_valid;
      // data may load during flush; vld_q alone decides if it is seen
      if (in_valid && in_ready) begin
        dec_q <= dec_d;
        pc_q  <= in_pc;
      end
    end
  end

  assign out_valid = vld_q;
  assign out_pc    = pc_q;
  assign alu_ctrl  = dec_q.alu_ctrl;
  assign rs1       = dec_q.rs1;
  assign rs2       = dec_q.rs2;
  assign rd        = dec_q.rd;
  assign imm       = dec_q.imm;
  assign alu_src_a = dec_q.alu_src_a;
  assign alu_src_b = dec_q.alu_src_b;
  assign reg_write = dec_q.reg_write;
  assign mem_read  = dec_q.mem_read;
  assign mem_write = dec_q.mem_write;
  assign branch    = dec_q.branch;
  assign jump      = dec_q.jump;
  assign funct3    = dec_q.funct3;
  assign illegal   = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: per-cycle reference model plus directed literal checks.
module tb_decode_stage;

  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, imm;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rs1, rs2, rd;
  logic        alu_src_a, alu_src_b, reg_write, mem_read, mem_write, branch, jump, illegal;
  logic [2:0]  funct3;

  int tests = 0, fails = 0;
  int cyc = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_ctrl(alu_ctrl), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
    .funct3(funct3), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        a, b, rw, mr, mw, br, j;
    logic [2:0]  f3;
    logic        ill;
  } exp_t;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: what each RV32I instruction must produce, read off the ISA tables.
  function automatic exp_t ref_dec(input logic [31:0] i);
    exp_t        e;
    logic        ok;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] brtab;
    logic [31:0] immi, imms, immb, immu, immj;
    f3    = i[14:12];
    f7    = i[31:25];
    brtab = 32'h3322_0088;
    immi  = {{20{i[31]}}, i[31:20]};
    imms  = {{20{i[31]}}, i[31:25], i[11:7]};
    immb  = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    immu  = {i[31:12], 12'h000};
    immj  = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    e = '0; ok = 1'b1;
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.f3 = f3;
    case (i[6:0])
      7'h33: begin ok = (f7 == 7'h00) || (f7 == 7'h20); e.ctrl = {i[30], f3}; e.rw = 1; end
      7'h13: begin
        e.b = 1; e.rw = 1; e.imm = immi; e.ctrl = {1'b0, f3};
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        if (f3 == 3'd5) begin ok = (f7 == 7'h00) || (f7 == 7'h20); e.ctrl = {i[30], f3}; end
      end
      7'h03: begin ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; e.mr = 1; e.rw = 1; e.b = 1; e.imm = immi; end
      7'h23: begin ok = f3 inside {3'd0, 3'd1, 3'd2}; e.mw = 1; e.b = 1; e.imm = imms; end
      7'h63: begin ok = !(f3 inside {3'd2, 3'd3}); e.ctrl = brtab[{f3, 2'b00} +: 4]; e.br = 1; e.imm = immb; end
      7'h37: begin e.rs1 = 5'd0; e.b = 1; e.rw = 1; e.imm = immu; end
      7'h17: begin e.a = 1; e.b = 1; e.rw = 1; e.imm = immu; end
      7'h6F: begin e.a = 1; e.b = 1; e.rw = 1; e.j = 1; e.imm = immj; end
      7'h67: begin ok = (f3 == 3'd0); e.b = 1; e.rw = 1; e.j = 1; e.imm = immi; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.ctrl = 4'h0; e.imm = '0; e.a = 0; e.b = 0;
      e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.j = 0; e.ill = 1;
    end
    return e;
  endfunction

  // Per-cycle compare against the model, sampled mid-cycle.
  exp_t        me;
  logic        mv = 1'b0;
  logic [31:0] mpc = '0;
  logic [31:0] got_pcs[$];

  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", out_valid, 0);
      mv = 1'b0;
    end else begin
      check("in_ready", in_ready, !mv || out_ready);
      check("out_valid", out_valid, mv);
      if (mv)
        check("bundle",
              {out_pc, alu_ctrl, rs1, rs2, rd, imm, alu_src_a, alu_src_b, reg_write,
               mem_read, mem_write, branch, jump, funct3, illegal},
              {mpc, me});
      if (out_valid && out_ready && !flush) got_pcs.push_back(out_pc);
      if (flush) mv = 1'b0;
      else if (!mv || out_ready) begin
        mv = in_valid;
        if (in_valid) begin me = ref_dec(in_instr); mpc = in_pc; end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    bit acc;
    int g;
    g = 0;
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    do begin
      @(negedge clk); acc = in_ready;
      tick(); g++;
    end while (!acc && g < 50);
    if (!acc) check("push_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1; tick(); tick();
  endtask

  logic [31:0] stream [4] = '{32'h002081B3, 32'h0040A283, 32'h0020A423, 32'h123453B7};

  initial begin
    int c0;
    #1 rst = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_outputs",
          {out_valid, out_pc, alu_ctrl, rs1, rs2, rd, imm, alu_src_a, alu_src_b, reg_write,
           mem_read, mem_write, branch, jump, funct3, illegal}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // model pins
    check("pin_srai_imm", ref_dec(32'h40315093).imm, 32'h403);
    check("pin_bltu_ctrl", ref_dec(32'h0020E463).ctrl, 4'h3);
    check("pin_jal_imm", ref_dec(32'h010000EF).imm, 32'h10);
    check("pin_ill", ref_dec(32'hFFFFFFFF).ill, 1);

    // directed decodes, checked right after acceptance
    push(32'h002081B3, 32'h200);
    check("add_ctrl", alu_ctrl, 4'h0);
    check("add_regs", {rs1, rs2, rd}, {5'd1, 5'd2, 5'd3});
    check("add_rw_srcb", {reg_write, alu_src_b}, 2'b10);
    push(32'h407302B3, 32'h204);
    check("sub_ctrl", alu_ctrl, 4'h8);
    push(32'h40315093, 32'h208);
    check("srai_ctrl", alu_ctrl, 4'hD);
    check("srai_imm", imm, 32'h00000403);
    push(32'h40000093, 32'h20C);
    check("addi400_ctrl", alu_ctrl, 4'h0);
    push(32'hFFF00093, 32'h210);
    check("addi_neg_imm", imm, 32'hFFFFFFFF);
    push(32'h00208463, 32'h214);
    check("beq_ctrl", alu_ctrl, 4'h8);
    check("beq_imm", imm, 32'h00000008);
    check("beq_br_rw", {branch, reg_write}, 2'b10);
    push(32'h0020E463, 32'h218);
    check("bltu_ctrl", alu_ctrl, 4'h3);
    push(32'hFFFFFFFF, 32'h21C);
    check("ill_valid", {out_valid, illegal}, 2'b11);
    check("ill_flags", {reg_write, mem_read, mem_write, branch, jump}, 0);
    // model-only coverage: jal, jalr, auipc, bad slli funct7, bad branch funct3
    push(32'h010000EF, 32'h220);
    push(32'h00008067, 32'h224);
    push(32'h00001217, 32'h228);
    push(32'h02001093, 32'h22C);
    push(32'h0020A463, 32'h230);
    drain();

    // unstalled streaming: one accept per cycle
    got_pcs.delete();
    c0 = cyc;
    for (int k = 0; k < 4; k++) push(stream[k], 32'h100 + 32'(k * 4));
    check("throughput_cycles", cyc - c0, 4);
    drain();
    check("stream_count", got_pcs.size(), 4);
    for (int k = 0; k < 4 && k < got_pcs.size(); k++)
      check("stream_order", got_pcs[k], 32'h100 + 32'(k * 4));

    // backpressure: out_ready low for cycles 2-4
    got_pcs.delete();
    fork
      for (int k = 0; k < 4; k++) push(stream[k], 32'h140 + 32'(k * 4));
      begin
        out_ready = 1'b1; tick();
        out_ready = 1'b0; tick();
        check("stall_in_ready", in_ready, 0);
        check("stall_hold_pc", out_pc, 32'h140);
        tick(); tick();
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", got_pcs.size(), 4);
    for (int k = 0; k < 4 && k < got_pcs.size(); k++)
      check("bp_order", got_pcs[k], 32'h140 + 32'(k * 4));

    // flush kills the held instruction and drops the same-cycle input
    got_pcs.delete();
    out_ready = 1'b0;
    push(32'h002081B3, 32'h300);
    in_valid = 1'b1; in_instr = 32'h407302B3; in_pc = 32'h304; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_kill", out_valid, 0);
    out_ready = 1'b1;
    tick();
    check("flush_drop", out_valid, 0);
    check("flush_delivered", got_pcs.size(), 0);

    // asynchronous reset while stalled
    out_ready = 1'b0;
    push(32'h0020E463, 32'h400);
    #5 rst = 1'b1;
    #1;
    check("async_rst_outputs",
          {out_valid, out_pc, alu_ctrl, rs1, rs2, rd, imm, alu_src_a, alu_src_b, reg_write,
           mem_read, mem_write, branch, jump, funct3, illegal}, 0);
    check("async_rst_in_ready", in_ready, 1);
    tick(); tick();
    rst = 1'b0;
    out_ready = 1'b1;
    push(32'h407302B3, 32'h500);
    check("post_rst_ctrl", alu_ctrl, 4'h8);
    check("post_rst_regs", {rs1, rs2, rd}, {5'd6, 5'd7, 5'd5});
    check("post_rst_pc", out_pc, 32'h500);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

RV32I instruction decode pipeline stage, the producer of the 4-bit ALU control word and operand selects that the execute-stage ALU consumes. It accepts one fetched instruction per cycle over a valid/ready handshake, decodes it combinationally, and registers the decoded bundle into a single pipeline register with stall and flush support. It sits between fetch and execute.

## Interface
- No parameters; XLEN is fixed at 32.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage can accept; combinational.
- `in_instr`  in  32  raw instruction.
- `in_pc`  in  32  instruction address.
- `flush`  in  1  kill the registered instruction and discard any same-cycle input.
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  execute accepts the bundle.
- `out_pc`  out  32  registered `in_pc`.
- `alu_ctrl`  out  4  ALU op, {bit30 qualifier, funct3}.
- `rs1`, `rs2`, `rd`  out  5 each  register indices.
- `imm`  out  32  sign-extended immediate.
- `alu_src_a`  out  1  1 = PC, 0 = rs1.
- `alu_src_b`  out  1  1 = imm, 0 = rs2.
- `reg_write`, `mem_read`, `mem_write`, `branch`, `jump`  out  1 each  control flags.
- `funct3`  out  3  passed through for branch condition and load/store width.
- `illegal`  out  1  instruction not in RV32I base subset.

## Operation
- ALU encoding: add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111.
- OP (0110011): ctrl = {instr[30], funct3}. alu_src_b = 0. reg_write = 1.
- OP-IMM (0010011): ctrl = {instr[30], funct3} only when funct3 is 001 or 101. Otherwise ctrl = {0, funct3}, so addi with imm[10] set is still add. alu_src_b = 1.
- LOAD: ctrl = add. mem_read = 1. reg_write = 1. I-immediate.
- STORE: ctrl = add. mem_write = 1. S-immediate.
- BRANCH: funct3 000/001 map to sub; 100/101 map to slt; 110/111 map to sltu. branch = 1. alu_src_b = 0. B-immediate.
- LUI: ctrl = add, rs1 forced to 0, U-immediate.
- AUIPC: ctrl = add, alu_src_a = 1, U-immediate.
- JAL: jump = 1, reg_write = 1, alu_src_a = 1, J-immediate.
- JALR: jump = 1, reg_write = 1, alu_src_b = 1, I-immediate.
- Illegal instructions (any other opcode, OP with funct7 not 0000000/0100000, shift-imm with bad funct7) set illegal = 1. All of reg_write, mem_read, mem_write, branch and jump are 0 for these. out_valid still rises, so execute can trap.
- Writes to x0 are not suppressed here.

## Timing
- Latency is 1 cycle: an input accepted at edge N is presented from edge N onward.
- `in_ready = !out_valid || out_ready`.
- Transfer on the input side when in_valid && in_ready. Transfer on the output side when out_valid && out_ready.
- Stall (out_valid && !out_ready): all outputs hold stable and in_ready = 0.
- Flush has priority over acceptance: next cycle out_valid = 0 regardless of in_valid or out_ready. Data registers may update, but only out_valid matters.
- Simultaneous output transfer and input transfer: the register reloads with no bubble, sustaining 1 instruction per cycle.
- Reset, including mid-stall: all outputs go to 0 immediately, so out_valid = 0. in_ready reads 1 while rst is held.

## Structure
- Package `rv32i_pkg` holds:
  - opcode constants;
  - `alu_op_t` enum carrying the encodings above (shared with the ALU);
  - the `decoded_t` packed struct bundling all decode outputs;
  - immediate-format enum.
- Sub-module `rv32i_decoder`: purely combinational, mapping instr to `decoded_t`.
- `decode_stage` contains only the handshake and the `decoded_t` pipeline register.

## Test plan
- Register ALU ops:
  - `0x002081B3` (add x3,x1,x2) -> alu_ctrl 0000, rs1 1, rs2 2, rd 3, reg_write 1, alu_src_b 0.
  - `0x407302B3` (sub x5,x6,x7) -> alu_ctrl 1000.
- Immediate qualifiers:
  - `0x40315093` (srai x1,x2,3) -> alu_ctrl 1101, imm `0x00000403`.
  - `0x40000093` (addi x1,x0,0x400) -> alu_ctrl 0000.
  - `0xFFF00093` -> imm `0xFFFFFFFF`.
- Branch: `0x00208463` (beq x1,x2,+8) -> alu_ctrl 1000, imm `0x00000008`, branch 1, reg_write 0.
  - Repeat with funct3 110 -> alu_ctrl 0011.
- Backpressure: stream 4 instructions with out_ready low for cycles 2-4 -> outputs frozen and in_ready 0 during the stall. Order is preserved with no loss or duplication, and throughput is 1/cycle when unstalled.
- Flush: flush with in_valid = 1 and out_valid = 1 -> out_valid 0 next cycle and the incoming instruction is dropped.
  - Illegal `0xFFFFFFFF` -> out_valid 1, illegal 1, all control flags 0.
- Reset: assert rst asynchronously mid-stall -> out_valid and all outputs 0 before the next clock edge. The first post-reset instruction decodes correctly.
